// File: rtl/dcore_mem_issuer.sv
// Core-side D-bus master: takes one load/store from the memory stage, issues it as a tagged
// line-wide request, waits for the matching tagged response and hands the selected word back.
module dcore_mem_issuer #(
    parameter int DATA_WIDTH = 512,
    parameter int WORDSIZE   = 64,
    parameter int TAG_WIDTH  = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic                  lsu_write,
    input  logic [WORDSIZE-1:0]   lsu_addr,
    input  logic [WORDSIZE-1:0]   lsu_wdata,
    output logic                  rsp_valid,
    output logic [WORDSIZE-1:0]   rsp_rdata,
    input  logic                  rsp_ready,
    output logic [WORDSIZE-1:0]   req,
    output logic [DATA_WIDTH-1:0] reqdata,
    output logic [DATA_WIDTH/WORDSIZE-1:0] reqwrite,
    output logic [TAG_WIDTH-1:0]  reqtag,
    output logic                  reqcyc,
    input  logic                  reqack,
    input  logic [DATA_WIDTH-1:0] resp,
    input  logic [TAG_WIDTH-1:0]  resptag,
    input  logic                  respcyc,
    output logic                  respack,
    output logic [7:0]            stray_cnt
);
    localparam int ID_WIDTH  = TAG_WIDTH - 5;
    localparam int LANES     = DATA_WIDTH / WORDSIZE;
    localparam int LANE_BITS = $clog2(LANES);
    localparam int OFF       = $clog2(WORDSIZE / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ACK,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic                    wr_q;
    logic [WORDSIZE-OFF-1:0] addr_q;
    logic [WORDSIZE-1:0]     wdata_q;
    logic [WORDSIZE-1:0]     rdata_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [LANE_BITS-1:0]    lane;
    logic [TAG_WIDTH-1:0]    tag;
    logic                    tag_hit;
    logic                    is_stray;

    // Only the word-aligned part of the address is kept; the low lane bits pick the word.
    assign lane     = addr_q[LANE_BITS-1:0];
    assign tag      = {~wr_q, 4'b0001, id_q};
    assign tag_hit  = respcyc && (resptag == tag);
    assign is_stray = respcyc && ((state == S_REQ) || (state == S_WAIT && resptag != tag));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (lsu_valid) state_nx = S_REQ;
            S_REQ:   if (reqack)    state_nx = S_WAIT;
            S_WAIT:  if (tag_hit)   state_nx = S_ACK;
            S_ACK:                  state_nx = S_DONE;
            S_DONE:  if (rsp_ready) state_nx = S_IDLE;
            default:                state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            id_q      <= '0;
            stray_cnt <= 8'd0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && lsu_valid) begin
                wr_q    <= lsu_write;
                addr_q  <= lsu_addr[WORDSIZE-1:OFF];
                wdata_q <= lsu_wdata;
            end
            // Stores report zero, so the captured word is cleared rather than taken from the bus.
            if (state == S_WAIT && tag_hit)
                rdata_q <= wr_q ? '0 : resp[int'(lane)*WORDSIZE +: WORDSIZE];
            if (state == S_ACK)
                id_q <= id_q + 1'b1;
            if (is_stray && stray_cnt != 8'hFF)
                stray_cnt <= stray_cnt + 8'd1;
        end
    end

    always_comb begin
        lsu_ready = 1'b0;
        reqcyc    = 1'b0;
        req       = '0;
        reqdata   = '0;
        reqwrite  = '0;
        reqtag    = '0;
        respack   = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        case (state)
            S_IDLE: lsu_ready = 1'b1;
            S_REQ: begin
                reqcyc = 1'b1;
                req    = {addr_q, {OFF{1'b0}}};
                reqtag = tag;
                if (wr_q) begin
                    reqdata  = {LANES{wdata_q}};
                    reqwrite = {{(LANES-1){1'b0}}, 1'b1} << lane;
                end
            end
            S_ACK:  respack = 1'b1;
            S_DONE: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
            end
            default: lsu_ready = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_dcore_mem_issuer.sv
// Bench for dcore_mem_issuer: scripted transactions with randomized timing, strays and junk,
// checked every cycle against a transaction-level expectation plus a few literal pins.
module tb_dcore_mem_issuer;
    logic         clk = 1'b0;
    logic         reset;
    logic         lsu_valid, lsu_ready, lsu_write;
    logic [63:0]  lsu_addr, lsu_wdata;
    logic         rsp_valid, rsp_ready;
    logic [63:0]  rsp_rdata;
    logic [63:0]  req;
    logic [511:0] reqdata;
    logic [7:0]   reqwrite;
    logic [12:0]  reqtag;
    logic         reqcyc, reqack;
    logic [511:0] resp;
    logic [12:0]  resptag;
    logic         respcyc, respack;
    logic [7:0]   stray_cnt;

    dcore_mem_issuer dut (
        .clk(clk), .reset(reset),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_write(lsu_write),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_ready(rsp_ready),
        .req(req), .reqdata(reqdata), .reqwrite(reqwrite), .reqtag(reqtag),
        .reqcyc(reqcyc), .reqack(reqack),
        .resp(resp), .resptag(resptag), .respcyc(respcyc), .respack(respack),
        .stray_cnt(stray_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit checkEn = 1'b0;

    // Expected outputs for the current cycle and the transaction-level model state.
    logic         eLsuReady, eReqcyc, eRespack, eRspValid;
    logic [63:0]  eReq, eRspRdata;
    logic [511:0] eReqdata;
    logic [7:0]   eReqwrite, eStray;
    logic [12:0]  eReqtag;
    int mId = 0;
    int mStray = 0;

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("lsu_ready", lsu_ready, eLsuReady);
            checkOutput("reqcyc", reqcyc, eReqcyc);
            checkOutput("req", req, eReq);
            checkOutput("reqdata", reqdata, eReqdata);
            checkOutput("reqwrite", reqwrite, eReqwrite);
            checkOutput("reqtag", reqtag, eReqtag);
            checkOutput("respack", respack, eRespack);
            checkOutput("rsp_valid", rsp_valid, eRspValid);
            checkOutput("rsp_rdata", rsp_rdata, eRspRdata);
            checkOutput("stray_cnt", stray_cnt, eStray);
        end
    end

    task automatic setExp(input bit idle);
        eLsuReady = idle;
        eReqcyc   = 1'b0;
        eReq      = '0;
        eReqdata  = '0;
        eReqwrite = '0;
        eReqtag   = '0;
        eRespack  = 1'b0;
        eRspValid = 1'b0;
        eRspRdata = '0;
        eStray    = 8'(mStray);
    endtask

    task automatic step(input bit strayNow);
        @(posedge clk);
        #1;
        if (strayNow && mStray < 255) mStray++;
    endtask

    task automatic junkLsu();
        lsu_valid = 1'($urandom);
        lsu_write = 1'($urandom);
        lsu_addr  = {$urandom, $urandom};
        lsu_wdata = {$urandom, $urandom};
    endtask

    function automatic logic [511:0] randLine();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // One full transaction. strayMode: 0 none, 1 random strays, 2 one stray tagged id+1 in the
    // first wait cycle, 3 stray on every wait cycle before the match.
    task automatic applyStimulus(input bit wr, input logic [63:0] a, input logic [63:0] wd,
                                 input logic [63:0] word, input int ackDly, input int respDly,
                                 input int strayMode, input int rdyDly, input bit abortWait);
        logic [511:0] line;
        logic [12:0]  tag, t;
        logic [7:0]   one;
        int           lane;
        bit           s;
        lane = int'(a[5:3]);
        tag  = {~wr, 4'b0001, 8'(mId)};
        one  = 8'd1;
        line = randLine();
        line[lane*64 +: 64] = word;

        setExp(1'b1);
        lsu_valid = 1'b1; lsu_write = wr; lsu_addr = a; lsu_wdata = wd;
        respcyc = 1'b0; reqack = 1'b0; rsp_ready = 1'($urandom);
        step(1'b0);

        for (int k = 0; k <= ackDly; k++) begin
            setExp(1'b0);
            eReqcyc   = 1'b1;
            eReq      = {a[63:3], 3'b000};
            eReqtag   = tag;
            eReqdata  = wr ? {8{wd}} : '0;
            eReqwrite = wr ? (one << lane) : 8'd0;
            junkLsu();
            rsp_ready = 1'($urandom);
            reqack  = (k == ackDly);
            s       = (strayMode == 1) && ($urandom_range(0, 3) == 0);
            respcyc = s;
            resptag = 13'($urandom);
            resp    = randLine();
            step(s);
        end
        reqack = 1'b0;

        for (int k = 0; k <= respDly; k++) begin
            setExp(1'b0);
            junkLsu();
            resp = randLine();
            if (k < respDly) begin
                s = (strayMode == 3) || (strayMode == 2 && k == 0) ||
                    (strayMode == 1 && $urandom_range(0, 2) == 0);
                respcyc = s;
                if (strayMode == 2) t = {tag[12:8], tag[7:0] + 8'd1};
                else do t = 13'($urandom); while (t == tag);
                resptag = s ? t : (1'($urandom) ? tag : t);
                step(s);
            end else begin
                respcyc = 1'b1;
                resptag = tag;
                resp    = line;
                if (abortWait) begin
                    reset = 1'b0;
                    step(1'b0);
                    reset = 1'b1;
                    respcyc = 1'b0;
                    lsu_valid = 1'b0;
                    mId = 0;
                    mStray = 0;
                    setExp(1'b1);
                    return;
                end
                step(1'b0);
            end
        end

        setExp(1'b0);
        eRespack = 1'b1;
        respcyc = 1'b0;
        junkLsu();
        step(1'b0);
        mId = (mId + 1) % 256;

        for (int k = 0; k <= rdyDly; k++) begin
            setExp(1'b0);
            eRspValid = 1'b1;
            eRspRdata = wr ? 64'd0 : word;
            junkLsu();
            rsp_ready = (k == rdyDly);
            step(1'b0);
        end
        rsp_ready = 1'b0;
        lsu_valid = 1'b0;
        setExp(1'b1);
    endtask

    initial begin
        logic [511:0] all55;
        logic [63:0]  w;
        bit           wr;
        all55 = {8{64'h55}};
        reset = 1'b0; lsu_valid = 1'b0; lsu_write = 1'b0; lsu_addr = '0; lsu_wdata = '0;
        rsp_ready = 1'b0; reqack = 1'b0; resp = '0; resptag = '0; respcyc = 1'b0;
        repeat (3) step(1'b0);
        setExp(1'b1);
        checkEn = 1'b1;
        @(negedge clk);
        checkOutput("reset lsu_ready", lsu_ready, 1'b1);
        checkOutput("reset reqcyc", reqcyc, 1'b0);
        checkOutput("reset rsp_valid", rsp_valid, 1'b0);
        checkOutput("reset stray_cnt", stray_cnt, 8'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        step(1'b0);

        $display("[TB] directed load");
        fork
            applyStimulus(1'b0, 64'h1000_0048, 64'd0, 64'hDEAD_BEEF, 0, 0, 0, 0, 1'b0);
            begin
                repeat (2) @(negedge clk);
                checkOutput("t1 req", req, 64'h1000_0048);
                checkOutput("t1 reqtag", reqtag, 13'h1100);
                checkOutput("t1 reqwrite", reqwrite, 8'h00);
                repeat (2) @(negedge clk);
                checkOutput("t1 respack", respack, 1'b1);
                @(negedge clk);
                checkOutput("t1 rsp_rdata", rsp_rdata, 64'hDEAD_BEEF);
            end
        join

        $display("[TB] directed store");
        fork
            applyStimulus(1'b1, 64'h38, 64'h55, 64'hFFFF_0000_1234_5678, 0, 0, 0, 0, 1'b0);
            begin
                repeat (2) @(negedge clk);
                checkOutput("t2 reqwrite", reqwrite, 8'h80);
                checkOutput("t2 reqtag", reqtag, 13'h0101);
                checkOutput("t2 reqdata", reqdata, all55);
                repeat (3) @(negedge clk);
                checkOutput("t2 rsp_valid", rsp_valid, 1'b1);
                checkOutput("t2 rsp_rdata", rsp_rdata, 64'd0);
            end
        join

        $display("[TB] delayed reqack");
        applyStimulus(1'b0, 64'h2000_0107, 64'd0, 64'hA5A5_0000_5A5A_FFFF, 5, 2, 0, 1, 1'b0);

        $display("[TB] stray then match");
        fork
            applyStimulus(1'b0, 64'h3000_0010, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 1, 2, 0, 1'b0);
            begin
                repeat (6) @(negedge clk);
                checkOutput("t4 stray_cnt", stray_cnt, 8'd1);
                checkOutput("t4 rsp_rdata", rsp_rdata, 64'h0123_4567_89AB_CDEF);
            end
        join

        $display("[TB] random mix");
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom);
            w  = {$urandom, $urandom};
            applyStimulus(wr, {$urandom, $urandom}, {$urandom, $urandom}, w,
                          $urandom_range(0, 4), $urandom_range(0, 4), 1, $urandom_range(0, 3), 1'b0);
        end

        $display("[TB] back-to-back loads across id wrap");
        for (int n = 0; n < 256; n++) begin
            applyStimulus(1'b0, {$urandom, $urandom}, 64'd0, {$urandom, $urandom},
                          $urandom_range(0, 1), $urandom_range(0, 1), 1,
                          (n % 50 == 0) ? 3 : $urandom_range(0, 1), 1'b0);
        end

        $display("[TB] stray counter saturation");
        applyStimulus(1'b0, 64'h40, 64'd0, 64'hCAFE, 0, 300, 3, 0, 1'b0);
        @(negedge clk);
        checkOutput("sat stray_cnt", stray_cnt, 8'd255);
        @(posedge clk); #1;

        $display("[TB] reset during wait");
        applyStimulus(1'b0, 64'h5000_0000, 64'd0, 64'hBEEF, 1, 2, 0, 0, 1'b1);
        @(negedge clk);
        checkOutput("t6 respack", respack, 1'b0);
        checkOutput("t6 rsp_valid", rsp_valid, 1'b0);
        checkOutput("t6 lsu_ready", lsu_ready, 1'b1);
        checkOutput("t6 stray_cnt", stray_cnt, 8'd0);
        @(posedge clk); #1;
        fork
            applyStimulus(1'b0, 64'h48, 64'd0, 64'h7777, 0, 0, 0, 0, 1'b0);
            begin
                repeat (2) @(negedge clk);
                checkOutput("t6 reqtag id0", reqtag, 13'h1100);
            end
        join
        step(1'b0);

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
